// File: rtl/key_tracker_if.sv
// Scan-code input and key-state output bundle for key_tracker.
interface key_tracker_if;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic       frame_start;
  logic [7:0] keyTrack;
  logic [7:0] key_live;
  logic [7:0] key_press;
  logic [7:0] key_release;

  modport master (
    output scan_valid, scan_code, frame_start,
    input  keyTrack, key_live, key_press, key_release
  );

  modport slave (
    input  scan_valid, scan_code, frame_start,
    output keyTrack, key_live, key_press, key_release
  );
endinterface

// File: rtl/key_tracker.sv
// PS/2 set-2 scan-code parser tracking eight lane keys, with frame-latched
// key vector (taps shorter than a frame still show for one frame) and
// one-cycle press/release strobes.
module key_tracker #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic         Clk,
  input logic         Reset,
  key_tracker_if.slave bus
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXT_BRK
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    live_q, live_d;
  logic [7:0]    press_q, press_d;
  logic [7:0]    release_q, release_d;
  logic [7:0]    tap_q, tap_d;
  logic [7:0]    track_q, track_d;
  logic [7:0]    hit;
  logic [7:0]    make_m;
  logic [7:0]    brk_m;

  // Lane decode: one-hot bit for mapped make codes, zero otherwise.
  function automatic logic [7:0] lane_mask(input logic [7:0] code);
    logic [7:0] m;
    m = '0;
    case (code)
      8'h1C:   m = 8'h80;
      8'h1B:   m = 8'h40;
      8'h23:   m = 8'h20;
      8'h2B:   m = 8'h10;
      8'h3B:   m = 8'h08;
      8'h42:   m = 8'h04;
      8'h4B:   m = 8'h02;
      8'h4C:   m = 8'h01;
      default: m = '0;
    endcase
    return m;
  endfunction

  assign hit = lane_mask(bus.scan_code);

  // Parser next state, prefix timeout, and key event decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    make_m  = '0;
    brk_m   = '0;
    if (bus.scan_valid) begin
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (bus.scan_code == 8'hF0)      state_d = ST_BRK;
          else if (bus.scan_code == 8'hE0) state_d = ST_EXT;
          else                             make_m  = hit;
        end
        ST_BRK: begin
          // E0/F0 decode to an empty mask, so a protocol error yields no event.
          state_d = ST_IDLE;
          brk_m   = hit;
        end
        ST_EXT:     state_d = (bus.scan_code == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (cnt_q == CNT_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Key state, strobes, sticky taps and frame latch.
  always_comb begin
    live_d    = (live_q | make_m) & ~brk_m;
    press_d   = make_m & ~live_q;
    release_d = brk_m & live_q;
    tap_d     = bus.frame_start ? make_m : (tap_q | make_m);
    track_d   = bus.frame_start ? (live_q | tap_q) : track_q;
  end

  // State registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      live_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
      tap_q     <= '0;
      track_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      live_q    <= live_d;
      press_q   <= press_d;
      release_q <= release_d;
      tap_q     <= tap_d;
      track_q   <= track_d;
    end
  end

  assign bus.keyTrack    = track_q;
  assign bus.key_live    = live_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = release_q;

endmodule

// File: tb/tb_key_tracker.sv
// Self-checking bench for key_tracker: directed test-plan sequences plus
// randomized byte streams against a queue-based reference model.
module tb_key_tracker;

  localparam int unsigned TO = 16;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  key_tracker_if bus();

  key_tracker #(.TIMEOUT_CYCLES(TO)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model state.
  logic [7:0]  m_live, m_tap, m_track, m_press, m_rel;
  logic [7:0]  pfx[$];
  int unsigned m_wait;

  logic [7:0] lane_codes [8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h3B, 8'h42, 8'h4B, 8'h4C};

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lane_of(input logic [7:0] code);
    for (int i = 0; i < 8; i++)
      if (lane_codes[i] == code) return 7 - i;
    return -1;
  endfunction

  task automatic model_reset();
    m_live = '0; m_tap = '0; m_track = '0; m_press = '0; m_rel = '0;
    pfx.delete();
    m_wait = 0;
  endtask

  // One clock of the reference: frame latch uses pre-event values.
  task automatic model_step(input logic v, input logic [7:0] c, input logic fs);
    int k;
    logic make, brk;
    make = 1'b0; brk = 1'b0; k = -1;
    m_press = '0; m_rel = '0;
    if (v) begin
      m_wait = 0;
      if (pfx.size() == 0) begin
        if (c == 8'hF0 || c == 8'hE0) pfx.push_back(c);
        else begin k = lane_of(c); make = (k >= 0); end
      end else if (pfx.size() == 1 && pfx[0] == 8'hF0) begin
        pfx.delete();
        k = lane_of(c); brk = (k >= 0);
      end else if (pfx.size() == 1 && pfx[0] == 8'hE0) begin
        if (c == 8'hF0) pfx.push_back(c);
        else pfx.delete();
      end else begin
        pfx.delete();
      end
    end else if (pfx.size() != 0) begin
      m_wait++;
      if (m_wait == TO) begin pfx.delete(); m_wait = 0; end
    end
    if (fs) begin
      m_track = m_live | m_tap;
      m_tap = '0;
    end
    if (make) begin
      if (!m_live[k]) m_press[k] = 1'b1;
      m_live[k] = 1'b1;
      m_tap[k]  = 1'b1;
    end
    if (brk) begin
      if (m_live[k]) m_rel[k] = 1'b1;
      m_live[k] = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".track"}, bus.keyTrack,    m_track);
    check({tag, ".live"},  bus.key_live,    m_live);
    check({tag, ".press"}, bus.key_press,   m_press);
    check({tag, ".rel"},   bus.key_release, m_rel);
  endtask

  // Called at a negedge: apply inputs, clock once, check at next negedge.
  task automatic step(input logic v, input logic [7:0] c, input logic fs, input string tag);
    bus.scan_valid  = v;
    bus.scan_code   = c;
    bus.frame_start = fs;
    @(posedge Clk);
    model_step(v, c, fs);
    @(negedge Clk);
    bus.scan_valid  = 1'b0;
    bus.frame_start = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b0;
    bus.scan_valid = 1'b0;
    bus.scan_code = '0;
    bus.frame_start = 1'b0;
    model_reset();
    @(negedge Clk);

    // Reset and single make
    do_reset("rst");
    check("rst.live0", bus.key_live, 8'h00);
    step(1, 8'h1C, 0, "mk");
    check("mk.live", bus.key_live, 8'h80);
    check("mk.press", bus.key_press, 8'h80);
    step(0, 8'h00, 0, "mk1");
    check("mk.press_once", bus.key_press, 8'h00);
    check("mk.track_hold", bus.keyTrack, 8'h00);
    step(0, 8'h00, 1, "mkf");
    check("mk.track", bus.keyTrack, 8'h80);

    // Typematic, break of an up key, real break
    do_reset("rst2");
    step(1, 8'h1C, 0, "tm0");
    step(1, 8'h1C, 0, "tm1");
    check("tm.press_single", bus.key_press, 8'h00);
    step(1, 8'h1C, 0, "tm2");
    step(1, 8'hF0, 0, "tm3");
    step(1, 8'h4C, 0, "tm4");
    check("tm.norel", bus.key_release, 8'h00);
    step(1, 8'hF0, 0, "tm5");
    step(1, 8'h1C, 0, "tm6");
    check("tm.live_up", bus.key_live, 8'h00);
    check("tm.rel", bus.key_release, 8'h80);
    step(0, 8'h00, 0, "tm7");

    // Tap inside one frame
    do_reset("rst3");
    step(0, 8'h00, 1, "tp0");
    step(1, 8'h23, 0, "tp1");
    step(1, 8'hF0, 0, "tp2");
    step(1, 8'h23, 0, "tp3");
    check("tp.live", bus.key_live, 8'h00);
    step(0, 8'h00, 1, "tp4");
    check("tp.track1", bus.keyTrack, 8'h20);
    step(0, 8'h00, 1, "tp5");
    check("tp.track2", bus.keyTrack, 8'h00);

    // Extended sequences ignored
    do_reset("rst4");
    step(1, 8'hE0, 0, "ex0");
    step(1, 8'h1C, 0, "ex1");
    step(1, 8'hE0, 0, "ex2");
    step(1, 8'hF0, 0, "ex3");
    step(1, 8'h1C, 0, "ex4");
    check("ex.live", bus.key_live, 8'h00);
    step(1, 8'h42, 0, "ex5");
    check("ex.live2", bus.key_live, 8'h04);

    // Prefix timeout
    do_reset("rst5");
    step(1, 8'hF0, 0, "to0");
    for (int i = 0; i < int'(TO); i++) step(0, 8'h00, 0, "to_w");
    step(1, 8'h4B, 0, "to1");
    check("to.live", bus.key_live, 8'h02);
    check("to.press", bus.key_press, 8'h02);

    // Event coincident with frame_start
    do_reset("rst6");
    step(1, 8'h3B, 1, "fs0");
    check("fs.track", bus.keyTrack, 8'h00);
    check("fs.live", bus.key_live, 8'h08);
    step(0, 8'h00, 1, "fs1");
    check("fs.track2", bus.keyTrack, 8'h08);

    // Reset in the middle of a break sequence
    do_reset("rst7");
    step(1, 8'h1C, 0, "rm0");
    step(1, 8'hF0, 0, "rm1");
    do_reset("rm.rst");
    check("rm.live0", bus.key_live, 8'h00);
    step(1, 8'h1C, 0, "rm2");
    check("rm.live", bus.key_live, 8'h80);
    check("rm.press", bus.key_press, 8'h80);

    // Randomized streams
    for (int n = 0; n < 3000; n++) begin
      logic       v, fs;
      logic [7:0] c;
      int unsigned r;
      r = $urandom % 10;
      if (r < 5)       c = lane_codes[$urandom % 8];
      else if (r == 5) c = 8'hF0;
      else if (r == 6) c = 8'hE0;
      else             c = 8'($urandom);
      v  = ($urandom % 3) != 0;
      fs = ($urandom % 12) == 0;
      if ($urandom % 600 == 0) do_reset("rnd.rst");
      step(v, c, fs, "rnd");
      if ($urandom % 60 == 0)
        for (int g = 0; g < int'(TO) - 2 + int'($urandom % 4); g++)
          step(0, 8'h00, ($urandom % 12) == 0, "rnd.gap");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_tracker.md
# key_tracker

Upstream stage of the static-rectangle renderer. Parses a PS/2 scan-code set 2 byte stream into the live up/down state of the eight lane keys. Produces the frame-stable `keyTrack[7:0]` vector that drives rectangle highlighting, plus one-cycle press and release strobes for downstream hit detection. A tap that starts and ends within one video frame is still shown for one frame.

## Interface
Parameters:
- TIMEOUT_CYCLES, 50000, maximum cycles a prefix state may wait for its next byte before returning to IDLE (1 ms at 50 MHz)

Ports:
- Clk  in  1  system clock; single clock domain
- Reset  in  1  asynchronous, active-high reset
- scan_valid  in  1  one-cycle strobe; scan_code is valid this cycle
- scan_code  in  8  received scan-code byte
- frame_start  in  1  one-cycle pulse once per frame (vsync)
- keyTrack  out  8  frame-latched key state; bit 7 = leftmost lane
- key_live  out  8  current key state, updated every event
- key_press  out  8  one-cycle strobe per key on up→down transition
- key_release  out  8  one-cycle strobe per key on down→up transition

## Operation
- Lane map (make codes), bit 7..0: A=0x1C, S=0x1B, D=0x23, F=0x2B, J=0x3B, K=0x42, L=0x4B, ;=0x4C. All other codes are unmapped.
- The FSM advances only on cycles with scan_valid=1. States and transitions:
  - IDLE
    - 0xF0 → BRK
    - 0xE0 → EXT
    - mapped code → make event, stay in IDLE
    - any other byte → ignored
  - BRK
    - 0xE0 or 0xF0 → protocol error; return to IDLE and discard the byte
    - mapped code → break event, then IDLE
    - unmapped code → IDLE
  - EXT
    - 0xF0 → EXT_BRK
    - any other byte → IDLE (extended keys are ignored)
  - EXT_BRK: any byte → IDLE, no event
- Make on a key already down (typematic repeat): no state change, no key_press.
- Break on a key already up: no state change, no key_release.
- Timeout counter:
  - Clears on entry to BRK, EXT or EXT_BRK.
  - Increments every cycle while in one of those states with scan_valid=0.
  - On reaching TIMEOUT_CYCLES-1 the FSM returns to IDLE and the pending prefix is discarded.
  - Counter width is clog2(TIMEOUT_CYCLES). It saturates and never wraps.
- Sticky register `tap[7:0]`: a bit is set by any make event on that key.
- On frame_start:
  - keyTrack ← key_live | tap.
  - tap ← make events occurring in that same cycle (all other bits clear).
- keyTrack changes only on frame_start.

## Timing
- Reset values:
  - keyTrack, key_live, key_press, key_release = 0x00
  - FSM = IDLE; timeout counter = 0; tap = 0x00
- scan_valid at cycle n:
  - key_live reflects the event at n+1.
  - key_press or key_release is high for cycle n+1 only.
- frame_start at cycle m: keyTrack updates at m+1 using key_live and tap as registered at m.
- An event in the same cycle as frame_start is excluded from this latch. It appears in key_live at m+1 and in keyTrack at the next frame_start.
- Back-to-back scan_valid on consecutive cycles must be accepted; no handshake or backpressure.
- key_press and key_release for different keys can never coincide, because there is one event per byte.
- Reset asserted mid-sequence (for example in BRK):
  - All state clears immediately.
  - Keys held across reset read as up until their next make code.

## Test plan
- Reset → all outputs 0x00. Bytes 0x1C → key_live=0x80 and key_press=0x80 for exactly one cycle; keyTrack stays 0x00 until frame_start, then becomes 0x80.
- Bytes 0x1C, 0x1C, 0x1C (typematic) → key_live=0x80 and a single key_press pulse. Then 0xF0, 0x4C → no change to bit 0, no release pulse. Then 0xF0, 0x1C → key_live=0x00 and key_release=0x80 for one cycle.
- Bytes 0x23, then 0xF0, 0x23, all between two frame_start pulses:
  - key_live returns to 0x00.
  - At the next frame_start, keyTrack=0x20.
  - At the following frame_start, keyTrack=0x00.
- Extended sequences 0xE0, 0x1C and 0xE0, 0xF0, 0x1C → no event, key_live unchanged. A subsequent 0x42 → key_live=0x04 (FSM back in IDLE).
- Byte 0xF0, then TIMEOUT_CYCLES idle cycles, then 0x4B → treated as make: key_live=0x02, key_press=0x02.
- Bytes 0x3B and frame_start in the same cycle:
  - keyTrack latches the prior state, 0x00.
  - key_live=0x08 at the next cycle.
  - The next frame_start gives keyTrack=0x08.
  - Separately, asserting Reset between 0xF0 and 0x1C → all outputs 0x00 and FSM in IDLE.
